// File: rtl/serial_twos_neg_if.sv
// Bundle of serial datapath signals for serial_twos_neg (source side = master).
// Optional zero flag exists only when SERIAL_TWOS_NEG_ZERO_DET_EN is defined.
interface serial_twos_neg_if #(
  parameter int LANES = 1
);
  logic             in_valid;
  logic             sof;
  logic [LANES-1:0] in_bit;
  logic [LANES-1:0] neg_en;
  logic             out_valid;
  logic [LANES-1:0] out_bit;
  logic             out_last;
  logic [LANES-1:0] ovf;
`ifdef SERIAL_TWOS_NEG_ZERO_DET_EN
  logic [LANES-1:0] zero;
`endif

  modport master (
`ifdef SERIAL_TWOS_NEG_ZERO_DET_EN
    input  zero,
`endif
    output in_valid, sof, in_bit, neg_en,
    input  out_valid, out_bit, out_last, ovf
  );

  modport slave (
`ifdef SERIAL_TWOS_NEG_ZERO_DET_EN
    output zero,
`endif
    input  in_valid, sof, in_bit, neg_en,
    output out_valid, out_bit, out_last, ovf
  );
endinterface

// File: rtl/serial_twos_neg.sv
// LANES-wide lock-step LSB-first serial two's-complement negator with framing and overflow.
// Define SERIAL_TWOS_NEG_ZERO_DET_EN to add the per-lane all-zero-word flag.
module serial_twos_neg #(
  parameter int W     = 8,
  parameter int LANES = 1
) (
  input  logic            clk,
  input  logic            r_n,
  serial_twos_neg_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_POS = CW'(W - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LANES-1:0] mode_q, mode_d;
  logic [LANES-1:0] seen_one_q, seen_one_d;
  logic [LANES-1:0] low_zero_q, low_zero_d;
  logic             out_valid_q, out_valid_d;
  logic [LANES-1:0] out_bit_q, out_bit_d;
  logic             out_last_q, out_last_d;
  logic [LANES-1:0] ovf_q, ovf_d;
  logic [LANES-1:0] zero_q, zero_d;

  logic             first;
  logic [CW-1:0]    pos;
  logic             is_last;
  logic [LANES-1:0] mode_cur;
  logic [LANES-1:0] seen_cur;
  logic [LANES-1:0] low_zero_cur;

  // Per-word state is replaced by fresh values on a first-of-word bit.
  always_comb begin
    first        = (cnt_q == '0) || bus.sof;
    pos          = first ? '0 : cnt_q;
    is_last      = (pos == LAST_POS);
    mode_cur     = first ? bus.neg_en : mode_q;
    seen_cur     = first ? '0 : seen_one_q;
    low_zero_cur = first ? '1 : low_zero_q;

    cnt_d       = cnt_q;
    mode_d      = mode_q;
    seen_one_d  = seen_one_q;
    low_zero_d  = low_zero_q;
    out_valid_d = bus.in_valid;
    out_bit_d   = out_bit_q;
    out_last_d  = 1'b0;
    ovf_d       = '0;
    zero_d      = '0;

    if (bus.in_valid) begin
      cnt_d      = is_last ? '0 : pos + CW'(1);
      mode_d     = mode_cur;
      seen_one_d = seen_cur | bus.in_bit;
      low_zero_d = low_zero_cur & ~bus.in_bit;
      out_bit_d  = bus.in_bit ^ (mode_cur & seen_cur);
      out_last_d = is_last;
      // Only -2^(W-1) (zero low bits, MSB set) negates to itself.
      ovf_d      = {LANES{is_last}} & mode_cur & low_zero_cur & bus.in_bit;
      zero_d     = {LANES{is_last}} & low_zero_cur & ~bus.in_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!r_n) begin
      cnt_q       <= '0;
      mode_q      <= '0;
      seen_one_q  <= '0;
      low_zero_q  <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= '0;
      out_last_q  <= 1'b0;
      ovf_q       <= '0;
      zero_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      seen_one_q  <= seen_one_d;
      low_zero_q  <= low_zero_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_last  = out_last_q;
  assign bus.ovf       = ovf_q;

`ifdef SERIAL_TWOS_NEG_ZERO_DET_EN
  assign bus.zero = zero_q;
`else
  logic unused_zero;
  assign unused_zero = ^zero_q;
`endif
endmodule

// File: tb/tb_serial_twos_neg.sv
// Scoreboard bench for serial_twos_neg at W=4, LANES=2 with hand-computed vectors.
module tb_serial_twos_neg;
  localparam int W     = 4;
  localparam int LANES = 2;

  typedef struct packed {
    logic [LANES-1:0] b;
    logic             last;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] zero;
  } exp_t;

  logic clk;
  logic r_n;
  logic monitor_en;
  int   n_checks;
  int   n_fails;
  exp_t exp_q[$];

  serial_twos_neg_if #(.LANES(LANES)) bus();

  serial_twos_neg #(.W(W), .LANES(LANES)) dut (
    .clk (clk),
    .r_n (r_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drives one accepted bit on the falling edge and queues its expected response.
  task automatic applyStimulus(input logic sof, input logic [LANES-1:0] bits,
                               input logic [LANES-1:0] neg, input logic [LANES-1:0] exp_bit,
                               input logic exp_last, input logic [LANES-1:0] exp_ovf,
                               input logic [LANES-1:0] exp_zero);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sof      = sof;
    bus.in_bit   = bits;
    bus.neg_en   = neg;
    e.b    = exp_bit;
    e.last = exp_last;
    e.ovf  = exp_ovf;
    e.zero = exp_zero;
    exp_q.push_back(e);
  endtask

  task automatic applyGap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.sof      = 1'b0;
      bus.in_bit   = 2'b11;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid bit.
  always @(posedge clk) begin
    #1;
    if (monitor_en) begin
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", {7'd0, bus.out_valid}, 8'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("out_bit",  {6'd0, bus.out_bit}, {6'd0, e.b});
          checkOutput("out_last", {7'd0, bus.out_last}, {7'd0, e.last});
          checkOutput("ovf",      {6'd0, bus.ovf}, {6'd0, e.ovf});
`ifdef SERIAL_TWOS_NEG_ZERO_DET_EN
          checkOutput("zero",     {6'd0, bus.zero}, {6'd0, e.zero});
`endif
        end
      end else begin
        checkOutput("idle_out_last", {7'd0, bus.out_last}, 8'd0);
        checkOutput("idle_ovf", {6'd0, bus.ovf}, 8'd0);
      end
    end
  end

  initial begin
    int waited;
    n_checks     = 0;
    n_fails      = 0;
    monitor_en   = 1'b0;
    r_n          = 1'b0;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    bus.in_bit   = '0;
    bus.neg_en   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", {7'd0, bus.out_valid}, 8'd0);
    checkOutput("reset_out_bit", {6'd0, bus.out_bit}, 8'd0);
    checkOutput("reset_out_last", {7'd0, bus.out_last}, 8'd0);
    checkOutput("reset_ovf", {6'd0, bus.ovf}, 8'd0);
    r_n        = 1'b1;
    monitor_en = 1'b1;

    $display("[TB] negate 6 on lane0, pass 6 on lane1");
    applyStimulus(1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b01, 2'b01, 1'b1, 2'b00, 2'b00);

    $display("[TB] -8 overflow on negating lane0 only");
    applyStimulus(1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 1'b1, 2'b01, 2'b00);

    $display("[TB] lane0 -5, lane1 pass 3, neg_en toggled mid-word");
    applyStimulus(1'b0, 2'b11, 2'b01, 2'b11, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b10, 2'b10, 2'b11, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b10, 2'b01, 1'b1, 2'b00, 2'b00);

    $display("[TB] gap mid-word then back-to-back word without sof");
    applyStimulus(1'b1, 2'b01, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b11, 2'b10, 1'b0, 2'b00, 2'b00);
    applyGap(3);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b11, 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b01, 1'b1, 2'b00, 2'b10);

    $display("[TB] sof aborts a word on its third bit");
    applyStimulus(1'b1, 2'b01, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b1, 2'b01, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b01, 1'b1, 2'b00, 2'b10);

    $display("[TB] reset after two bits, then all-zero word");
    applyStimulus(1'b1, 2'b01, 2'b11, 2'b01, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    r_n          = 1'b0;
    bus.in_valid = 1'b1;
    bus.sof      = 1'b0;
    bus.in_bit   = 2'b11;
    @(negedge clk);
    r_n          = 1'b1;
    bus.in_valid = 1'b0;
    checkOutput("midreset_out_valid", {7'd0, bus.out_valid}, 8'd0);
    checkOutput("midreset_out_bit", {6'd0, bus.out_bit}, 8'd0);
    checkOutput("midreset_out_last", {7'd0, bus.out_last}, 8'd0);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 2'b00, 2'b11);
    applyGap(1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
